// File: rtl/game_pkg.sv
// Shared game constants and the formation FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_pkg;

    localparam int RES_H  = 640;   // screen width in px
    localparam int CELL_W = 32;    // horizontal pitch of one invader cell
    localparam int CELL_H = 24;    // vertical pitch of one invader cell

    typedef enum logic [1:0] {
        MARCH   = 2'd0,
        CLEARED = 2'd1,
        LANDED  = 2'd2
    } state_t;

endpackage

// File: rtl/invader_formation_if.sv
// Bundle between the collision unit / renderer and the formation controller.
// Latency: n/a (wires only).
// Backpressure: none; hits and frame pulses are fire-and-forget.
// Ports: restart/frame/hit_valid/hit_index flow into the controller (slave),
//        alive/grid_x/grid_y/alive_count/cleared/landed flow out of it.
interface invader_formation_if #(
    parameter int ROWS = 5,
    parameter int COLS = 11
);
    localparam int N  = ROWS * COLS;
    localparam int IW = $clog2(N);

    logic          restart;
    logic          frame;
    logic          hit_valid;
    logic [IW-1:0] hit_index;
    logic [N-1:0]  alive;
    logic [9:0]    grid_x;
    logic [9:0]    grid_y;
    logic [IW:0]   alive_count;
    logic          cleared;
    logic          landed;

    modport master (
        output restart, frame, hit_valid, hit_index,
        input  alive, grid_x, grid_y, alive_count, cleared, landed
    );

    modport slave (
        input  restart, frame, hit_valid, hit_index,
        output alive, grid_x, grid_y, alive_count, cleared, landed
    );

endinterface

// File: rtl/grid_bounds.sv
// Live bounding box of the alive mask: first/last live column, last live row.
// Latency: purely combinational.
// Backpressure: none.
// Ports: mask_i (row-major, index = row*COLS + col) in; first_col_o,
//        last_col_o, last_row_o out (all zero when the mask is empty).
module grid_bounds #(
    parameter  int ROWS = 5,
    parameter  int COLS = 11,
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic [ROWS*COLS-1:0] mask_i,
    output logic [CW-1:0]        first_col_o,
    output logic [CW-1:0]        last_col_o,
    output logic [RW-1:0]        last_row_o
);

    logic [COLS-1:0] col_any;
    logic [ROWS-1:0] row_any;

    always_comb begin
        col_any     = '0;
        row_any     = '0;
        first_col_o = '0;
        last_col_o  = '0;
        last_row_o  = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (mask_i[r*COLS + c]) begin
                    col_any[c] = 1'b1;
                    row_any[r] = 1'b1;
                end
            end
        end
        // Scanning downwards leaves the lowest set column as the final write.
        for (int c = COLS - 1; c >= 0; c--) begin
            if (col_any[c]) first_col_o = CW'(c);
        end
        for (int c = 0; c < COLS; c++) begin
            if (col_any[c]) last_col_o = CW'(c);
        end
        for (int r = 0; r < ROWS; r++) begin
            if (row_any[r]) last_row_o = RW'(r);
        end
    end

endmodule

// File: rtl/invader_formation.sv
// Invader grid controller: alive mask, horizontal march with edge drop,
// alive-scaled march rate, frame-stable snapshot for the renderer.
// Latency: hits/state visible 1 cycle after the event; snapshot 1 cycle after frame.
// Backpressure: none; one hit accepted per cycle, never dropped.
// Ports: clk, rst_n (async, active low); bus (slave modport) carries
//        restart/frame/hit in and the published snapshot/status out.
module invader_formation #(
    parameter int ROWS        = 5,
    parameter int COLS        = 11,
    parameter int RES_H       = game_pkg::RES_H,
    parameter int CELL_W      = game_pkg::CELL_W,
    parameter int CELL_H      = game_pkg::CELL_H,
    parameter int STEP_X      = 2,
    parameter int STEP_Y      = 16,
    parameter int START_X     = 64,
    parameter int START_Y     = 48,
    parameter int FLOOR_Y     = 420,
    parameter int BASE_PERIOD = 16,
    parameter int PER_INVADER = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    invader_formation_if.slave  bus
);
    import game_pkg::*;

    localparam int N         = ROWS * COLS;
    localparam int IW        = $clog2(N);
    localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int MAX_LIMIT = BASE_PERIOD + (N - 1) * PER_INVADER;
    localparam int TW        = $clog2(MAX_LIMIT + 1);

    // 11-bit geometry keeps x + grid width + step from wrapping.
    localparam logic [10:0] G_CELL_W = 11'(CELL_W);
    localparam logic [10:0] G_CELL_H = 11'(CELL_H);
    localparam logic [10:0] G_STEP_X = 11'(STEP_X);
    localparam logic [10:0] G_STEP_Y = 11'(STEP_Y);
    localparam logic [10:0] G_RES_H  = 11'(RES_H);
    localparam logic [10:0] G_FLOOR  = 11'(FLOOR_Y);
    localparam logic [10:0] G_X0     = 11'(START_X);
    localparam logic [10:0] G_Y0     = 11'(START_Y);

    // Working state
    state_t        state_q, state_d;
    logic [N-1:0]  mask_q, mask_d;
    logic [10:0]   x_q, x_d;
    logic [10:0]   y_q, y_d;
    logic          dir_q, dir_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [IW:0]   count_q, count_d;

    // Published snapshot
    logic [N-1:0]  alive_q;
    logic [9:0]    gx_q;
    logic [9:0]    gy_q;

    logic [CW-1:0] first_col;
    logic [CW-1:0] last_col;
    logic [RW-1:0] last_row;

    logic [31:0]   limit;
    logic          move_fire;
    logic          dropped;
    logic          hit_ok;

    // Bounds always come from the pre-hit mask, so a coincident move ignores the hit.
    grid_bounds #(.ROWS(ROWS), .COLS(COLS)) u_bounds (
        .mask_i      (mask_q),
        .first_col_o (first_col),
        .last_col_o  (last_col),
        .last_row_o  (last_row)
    );

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        count_d = count_q;
        dropped = 1'b0;

        // count_q is never 0 while marching, so the wrap below is never consumed.
        limit     = 32'(BASE_PERIOD) + (32'(count_q) - 32'd1) * 32'(PER_INVADER);
        // Comparing with >= lets a shrinking limit fire immediately.
        move_fire = (state_q == MARCH) && ((32'(timer_q) + 32'd1) >= limit);
        hit_ok    = bus.hit_valid && (32'(bus.hit_index) < 32'(N)) && mask_q[bus.hit_index];

        if (bus.restart) begin
            state_d = MARCH;
            mask_d  = {N{1'b1}};
            x_d     = G_X0;
            y_d     = G_Y0;
            dir_d   = 1'b1;
            timer_d = '0;
            count_d = (IW+1)'(N);
        end else begin
            if (state_q == MARCH) begin
                if (move_fire) begin
                    timer_d = '0;
                    if (dir_q && ((x_q + (11'(last_col) + 11'd1) * G_CELL_W + G_STEP_X) > G_RES_H)) begin
                        y_d     = y_q + G_STEP_Y;
                        dir_d   = 1'b0;
                        dropped = 1'b1;
                    end else if (!dir_q && ((x_q + 11'(first_col) * G_CELL_W) < G_STEP_X)) begin
                        y_d     = y_q + G_STEP_Y;
                        dir_d   = 1'b1;
                        dropped = 1'b1;
                    end else if (dir_q) begin
                        x_d = x_q + G_STEP_X;
                    end else begin
                        // A left-inset formation can sit closer to 0 than one step.
                        x_d = (x_q >= G_STEP_X) ? (x_q - G_STEP_X) : 11'd0;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            if (hit_ok) begin
                mask_d[bus.hit_index] = 1'b0;
                count_d               = count_q - (IW+1)'(1);
            end

            // Clearing wins over landing when both happen on the same edge.
            if (state_q == MARCH) begin
                if (count_d == '0) begin
                    state_d = CLEARED;
                end else if (dropped &&
                             ((y_d + (11'(last_row) + 11'd1) * G_CELL_H) >= G_FLOOR)) begin
                    state_d = LANDED;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MARCH;
            mask_q  <= {N{1'b1}};
            x_q     <= G_X0;
            y_q     <= G_Y0;
            dir_q   <= 1'b1;
            timer_q <= '0;
            count_q <= (IW+1)'(N);
            alive_q <= {N{1'b1}};
            gx_q    <= G_X0[9:0];
            gy_q    <= G_Y0[9:0];
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
            count_q <= count_d;
            if (bus.restart) begin
                alive_q <= {N{1'b1}};
                gx_q    <= G_X0[9:0];
                gy_q    <= G_Y0[9:0];
            end else if (bus.frame) begin
                // Snapshot the registered working state, not this cycle's update.
                alive_q <= mask_q;
                gx_q    <= x_q[9:0];
                gy_q    <= y_q[9:0];
            end
        end
    end

    assign bus.alive       = alive_q;
    assign bus.grid_x      = gx_q;
    assign bus.grid_y      = gy_q;
    assign bus.alive_count = count_q;
    assign bus.cleared     = (state_q == CLEARED);
    assign bus.landed      = (state_q == LANDED);

endmodule

// File: tb/tb_invader_formation.sv
module tb_invader_formation;

    localparam int ROWS        = 5;
    localparam int COLS        = 11;
    localparam int N           = ROWS * COLS;
    localparam int IW          = $clog2(N);
    localparam int RES_H       = 640;
    localparam int CELL_W      = 32;
    localparam int CELL_H      = 24;
    localparam int STEP_X      = 2;
    localparam int STEP_Y      = 16;
    localparam int START_X     = 64;
    localparam int START_Y     = 48;
    localparam int FLOOR_Y     = 420;
    localparam int BASE_PERIOD = 4;    // shortened march so full sweeps fit the cycle budget
    localparam int PER_INVADER = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    invader_formation_if #(.ROWS(ROWS), .COLS(COLS)) bus();

    invader_formation #(
        .ROWS(ROWS), .COLS(COLS), .RES_H(RES_H), .CELL_W(CELL_W), .CELL_H(CELL_H),
        .STEP_X(STEP_X), .STEP_Y(STEP_Y), .START_X(START_X), .START_Y(START_Y),
        .FLOOR_Y(FLOOR_Y), .BASE_PERIOD(BASE_PERIOD), .PER_INVADER(PER_INVADER)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (grid of booleans + plain integers) ----
    bit           m_alive [ROWS][COLS];
    int           m_x, m_y, m_elapsed, m_count;
    bit           m_right, m_cleared, m_landed;
    logic [N-1:0] p_alive;
    int           p_x, p_y;

    function automatic logic [N-1:0] pack_mask();
        logic [N-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v[r*COLS + c] = m_alive[r][c];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                m_alive[r][c] = 1'b1;
        m_x = START_X; m_y = START_Y; m_right = 1'b1; m_elapsed = 0; m_count = N;
        m_cleared = 1'b0; m_landed = 1'b0;
        p_alive = pack_mask(); p_x = START_X; p_y = START_Y;
    endtask

    task automatic model_step(input bit rs, input bit fr, input bit hv, input int hi);
        int  fc, lc, lr, per;
        bit  drop;
        if (rs) begin
            model_reset();
            return;
        end
        if (fr) begin
            p_alive = pack_mask(); p_x = m_x; p_y = m_y;
        end
        drop = 1'b0;
        fc = COLS; lc = -1; lr = -1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (m_alive[r][c]) begin
                    if (c < fc) fc = c;
                    if (c > lc) lc = c;
                    if (r > lr) lr = r;
                end
        if (!m_cleared && !m_landed) begin
            per = BASE_PERIOD + (m_count - 1) * PER_INVADER;
            if (m_elapsed + 1 >= per) begin
                m_elapsed = 0;
                if (m_right && (m_x + (lc + 1) * CELL_W + STEP_X > RES_H)) begin
                    m_y += STEP_Y; m_right = 1'b0; drop = 1'b1;
                end else if (!m_right && (m_x + fc * CELL_W < STEP_X)) begin
                    m_y += STEP_Y; m_right = 1'b1; drop = 1'b1;
                end else if (m_right) begin
                    m_x += STEP_X;
                end else begin
                    m_x = (m_x >= STEP_X) ? m_x - STEP_X : 0;
                end
            end else begin
                m_elapsed++;
            end
            if (hv && hi < N && m_alive[hi / COLS][hi % COLS]) begin
                m_alive[hi / COLS][hi % COLS] = 1'b0;
                m_count--;
            end
            if (m_count == 0) m_cleared = 1'b1;
            else if (drop && (m_y + (lr + 1) * CELL_H >= FLOOR_Y)) m_landed = 1'b1;
        end else if (hv && hi < N && m_alive[hi / COLS][hi % COLS]) begin
            m_alive[hi / COLS][hi % COLS] = 1'b0;
            m_count--;
        end
    endtask

    task automatic compare_outputs();
        check("alive",       64'(bus.alive),       64'(p_alive));
        check("grid_x",      64'(bus.grid_x),      64'(p_x));
        check("grid_y",      64'(bus.grid_y),      64'(p_y));
        check("alive_count", 64'(bus.alive_count), 64'(m_count));
        check("cleared",     64'(bus.cleared),     64'(m_cleared));
        check("landed",      64'(bus.landed),      64'(m_landed));
    endtask

    // One clock: drive inputs, clock DUT and model together, compare after the edge.
    task automatic cyc(input bit rs, input bit fr, input bit hv, input int hi);
        bus.restart   = rs;
        bus.frame     = fr;
        bus.hit_valid = hv;
        bus.hit_index = IW'(hi);
        @(posedge clk);
        model_step(rs, fr, hv, hi);
        #1;
        compare_outputs();
        bus.restart   = 1'b0;
        bus.frame     = 1'b0;
        bus.hit_valid = 1'b0;
    endtask

    task automatic run(input int cycles, input int fper);
        for (int i = 0; i < cycles; i++) cyc(1'b0, (i % fper) == fper - 1, 1'b0, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_alive"},   64'(bus.alive),       64'({N{1'b1}}));
        check({tag, "_grid_x"},  64'(bus.grid_x),      64'(START_X));
        check({tag, "_grid_y"},  64'(bus.grid_y),      64'(START_Y));
        check({tag, "_count"},   64'(bus.alive_count), 64'(N));
        check({tag, "_cleared"}, 64'(bus.cleared),     64'd0);
        check({tag, "_landed"},  64'(bus.landed),      64'd0);
    endtask

    int order [N];
    int budget;

    initial begin
        rst_n         = 1'b0;
        bus.restart   = 1'b0;
        bus.frame     = 1'b0;
        bus.hit_valid = 1'b0;
        bus.hit_index = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Full grid marches right; x=288 is the last step before the drop.
        run(7000, 100);
        check("march_grid_y", 64'(bus.grid_y), 64'd64);
        check("march_grid_x", 64'(bus.grid_x), 64'd274);

        // Columns 9 and 10 gone: right reversal moves out to x=352.
        cyc(1'b1, 1'b0, 1'b0, 0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 9; c < COLS; c++)
                cyc(1'b0, 1'b0, 1'b1, r * COLS + c);
        check("edge_count", 64'(bus.alive_count), 64'd45);
        run(7600, 100);
        check("edge_grid_y", 64'(bus.grid_y), 64'd64);

        // Hit coincident with frame shows up in the next snapshot only.
        cyc(1'b1, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b1, 1'b1, 0);
        check("hitf_alive0", 64'(bus.alive[0]), 64'd1);
        check("hitf_count",  64'(bus.alive_count), 64'd54);
        cyc(1'b0, 1'b1, 1'b0, 0);
        check("hitf_alive0_next", 64'(bus.alive[0]), 64'd0);

        // Dead and out-of-range indices are ignored.
        cyc(1'b0, 1'b0, 1'b1, 0);
        cyc(1'b0, 1'b0, 1'b1, 55);
        cyc(1'b0, 1'b0, 1'b1, 63);
        check("invalid_count", 64'(bus.alive_count), 64'd54);

        // Random hits and frames against the model.
        for (int i = 0; i < 3000; i++)
            cyc(1'b0, $urandom_range(0, 19) == 0, $urandom_range(0, 15) == 0,
                int'($urandom_range(0, 63)));

        // Kill everything in a shuffled order.
        cyc(1'b1, 1'b0, 1'b0, 0);
        for (int k = 0; k < N; k++) order[k] = k;
        for (int k = N - 1; k > 0; k--) begin
            int j, t;
            j = int'($urandom_range(0, k));
            t = order[k]; order[k] = order[j]; order[j] = t;
        end
        for (int k = 0; k < N; k++) cyc(1'b0, 1'b0, 1'b1, order[k]);
        check("clear_flag",  64'(bus.cleared), 64'd1);
        check("clear_count", 64'(bus.alive_count), 64'd0);
        run(300, 50);
        cyc(1'b1, 1'b0, 1'b0, 0);
        check_reset_values("restart");

        // Keep only the bottom-row corners so drops come quickly; expect landing at y=304.
        for (int k = 0; k < N; k++)
            if (k != 44 && k != 54) cyc(1'b0, 1'b0, 1'b1, k);
        for (budget = 0; budget < 20000 && !bus.landed; budget++)
            cyc(1'b0, (budget % 50) == 49, 1'b0, 0);
        check("landed", 64'(bus.landed), 64'd1);
        cyc(1'b0, 1'b1, 1'b0, 0);
        check("land_grid_y", 64'(bus.grid_y), 64'd304);
        run(100, 25);

        // Async reset in the middle of a march.
        cyc(1'b1, 1'b0, 1'b0, 0);
        run(300, 100);
        check("pre_arst_grid_x", 64'(bus.grid_x), 64'd74);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("arst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(200, 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
